// File: rtl/tt_scanner.sv
// Truth-table scanner: steps drv through every input vector and captures s_in into a minterm mask.
// Latency: 2^N_IN*(SETTLE+1) cycles from accepted start to done; all outputs registered.
// No backpressure: start is taken only while idle. Optional checker built with TT_SCAN_COMPARE_EN.
module tt_scanner #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 s_in,
    output logic [N_IN-1:0]      drv,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   mask,
    output logic                 mismatch,
    output logic [N_IN-1:0]      first_err
);
    localparam logic [3:0]      SETTLE_W = 4'(SETTLE);
    localparam logic [N_IN-1:0] LAST     = N_IN'((1 << N_IN) - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       sample;
    logic       accept;

    assign sample = (state == RUN) && (cnt == 4'd0);
    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            drv   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            mask  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        drv   <= '0;
                        cnt   <= SETTLE_W;
                        mask  <= '0;
                    end
                end
                RUN: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        mask[drv] <= s_in;
                        if (drv != LAST) begin
                            drv <= drv + N_IN'(1);
                            cnt <= SETTLE_W;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            drv   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TT_SCAN_COMPARE_EN
    // Only the first differing vector is recorded; later ones leave first_err alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch  <= 1'b0;
            first_err <= '0;
        end else if (accept) begin
            mismatch  <= 1'b0;
            first_err <= '0;
        end else if (sample && (s_in != expected[drv]) && !mismatch) begin
            mismatch  <= 1'b1;
            first_err <= drv;
        end
    end
`else
    logic unused_expected;
    assign unused_expected = ^expected;
    assign mismatch  = 1'b0;
    assign first_err = '0;
`endif

endmodule

// File: tb/tb_tt_scanner.sv
// Directed bench for tt_scanner: SETTLE=0 and SETTLE=2 instances scanning a fixed 3-input function.
module tb_tt_scanner;
`ifdef TT_SCAN_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, start, start2, s_in, s_in2;
    logic [7:0] expected, expected2;
    logic [2:0] drv, drv2, first_err, first_err2;
    logic       busy, busy2, done, done2, mismatch, mismatch2;
    logic [7:0] mask, mask2;

    always #5 clk = ~clk;

    function automatic logic fut(input logic [2:0] v);
        logic x, y, z;
        x = v[2]; y = v[1]; z = v[0];
        return (~x & ~y & z) | (~x & y & z) | (x & y & ~z) | (x & y & z);
    endfunction

    assign s_in  = fut(drv);
    assign s_in2 = fut(drv2);

    tt_scanner #(.N_IN(3), .SETTLE(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .s_in(s_in),
        .drv(drv), .busy(busy), .done(done), .mask(mask), .mismatch(mismatch), .first_err(first_err)
    );

    tt_scanner #(.N_IN(3), .SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .expected(expected2), .s_in(s_in2),
        .drv(drv2), .busy(busy2), .done(done2), .mask(mask2), .mismatch(mismatch2), .first_err(first_err2)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Runs one SETTLE=0 scan from the current cycle; optionally re-pulses start at E0+restart_at.
    task automatic scan0(input logic [7:0] exp_in, input int restart_at,
                         output int done_at, output int ndone);
        done_at = -1;
        ndone   = 0;
        expected = exp_in;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_at_e0", busy, 1);
        chk("drv_at_e0", drv, 0);
        for (int c = 1; c <= 12; c++) begin
            if (c == restart_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (c < 8) begin
                chk("drv_step", drv, c);
                chk("busy_run", busy, 1);
            end else if (c == 8) begin
                chk("drv_end", drv, 0);
                chk("busy_end", busy, 0);
            end
        end
    endtask

    typedef struct {
        logic [7:0] exp_in;
        logic [7:0] mask;
        logic       mis;
        logic [2:0] ferr;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int done_at, ndone;

        vecs[0] = '{8'hCA, 8'hCA, 1'b0, 3'd0};
        vecs[1] = '{8'hCB, 8'hCA, 1'b1, 3'd0};
        vecs[2] = '{8'h4A, 8'hCA, 1'b1, 3'd7};
        vecs[3] = '{8'h00, 8'hCA, 1'b1, 3'd1};

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        expected = 8'h00; expected2 = 8'hCA;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_drv", drv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mask", mask, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_first_err", first_err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            scan0(vecs[i].exp_in, 0, done_at, ndone);
            chk("done_cycle", done_at, 8);
            chk("done_count", ndone, 1);
            chk("mask", mask, vecs[i].mask);
            chk("mismatch", mismatch, CMP ? vecs[i].mis : 1'b0);
            chk("first_err", first_err, CMP ? vecs[i].ferr : 3'd0);
        end

        // start during RUN must be ignored
        scan0(8'hCA, 3, done_at, ndone);
        chk("restart_done_cycle", done_at, 8);
        chk("restart_done_count", ndone, 1);
        chk("restart_mask", mask, 8'hCA);

        // back-to-back: start while done is high gives E0 on the next edge
        expected = 8'hCA;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_done1", done, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_done_low", done, 0);
        chk("b2b_mask_cleared", mask, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_done2", done, 1);
        chk("b2b_mask", mask, 8'hCA);

        // reset mid-scan at E0+4
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("partial_mask", mask, 8'h0A);
        chk("partial_drv", drv, 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_drv", drv, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_mask", mask, 0);
        chk("mid_rst_mismatch", mismatch, 0);
        chk("mid_rst_first_err", first_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        scan0(8'hCA, 0, done_at, ndone);
        chk("post_rst_done_cycle", done_at, 8);
        chk("post_rst_mask", mask, 8'hCA);
        chk("post_rst_mismatch", mismatch, 0);

        // SETTLE=2 instance: each vector held three cycles
        done_at = -1;
        ndone = 0;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("s2_busy_e0", busy2, 1);
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (done2) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (c < 24) chk("s2_drv_hold", drv2, c / 3);
        end
        chk("s2_done_cycle", done_at, 24);
        chk("s2_done_count", ndone, 1);
        chk("s2_mask", mask2, 8'hCA);
        chk("s2_mismatch", mismatch2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
